i2c_eeprom_target: RTL and testbench
====================================

# i2c_eeprom_target

Synthesizable I2C target that emulates a 24xx-series serial EEPROM (two-byte word address, sequential read/write) on the board's open-drain I2C bus. It is the responder end of the I2C master in the top level. It lets the master be exercised in hardware against a second FPGA or a loopback header, and in simulation without the vendor behavioural model. Storage is an internal register/block RAM array. The bus is oversampled by the system clock.

## Interface
Parameters:
- `ADDR_W`, 8: implemented word-address bits; memory depth is 2^ADDR_W bytes. Upper received address bits are ignored.
- `DEV_ID`, 4'b1010: fixed upper four bits of the control byte.

Ports:
- `clk`, in, 1: system clock. Must be at least 16× the SCL frequency.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `scl_in`, in, 1: raw SCL pin state (target never stretches the clock).
- `sda_in`, in, 1: raw SDA pin state.
- `sda_oe`, out, 1: 1 = pull SDA low. The top level builds the open-drain driver as `sda = sda_oe ? 0 : z`.
- `chip_sel`, in, 3: A2..A0 strap, compared with control-byte bits 3:1.
- `wp`, in, 1: write protect. 1 = data bytes are NACKed and not stored.
- `busy`, out, 1: high from an address-matched START until STOP/START/abort.
- `wr_pulse`, out, 1: one-clk pulse each time a byte is committed to memory.

## Operation
- Input conditioning: `scl_in` and `sda_in` each pass through a 2-FF synchronizer, then a history FF.
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - SCL rise/fall = edge of the synchronized SCL.
- Data is sampled on SCL rise. `sda_oe` changes only on SCL fall.
- States: IDLE, CTRL, CTRL_ACK, AH, AH_ACK, AL, AL_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
- START in any state → CTRL with bit counter = 0. This covers repeated start.
- STOP in any state → IDLE and `sda_oe`=0, whether mid-byte or mid-ACK.
- CTRL: shift in 8 bits MSB first.
  - If bits 7:4 = DEV_ID and bits 3:1 = `chip_sel` → CTRL_ACK.
  - Otherwise → IGNORE: no ACK, wait for START/STOP.
- CTRL_ACK: drive ACK for one SCL period.
  - R/W=0 → AH.
  - R/W=1 → RDATA, loading `mem[ptr]`.
- AH/AL: receive the address high/low byte, always ACKed. After AL_ACK, `ptr` = {AH,AL}[ADDR_W-1:0], then → WDATA.
- WDATA: the 8th bit completes the byte.
  - `wp`=0: write `mem[ptr]`, pulse `wr_pulse`, increment `ptr`, ACK.
  - `wp`=1: NACK, no write, `ptr` unchanged, → IGNORE.
- WDATA_ACK → WDATA for the next byte; there is no byte-count limit.
- RDATA: shift out the byte MSB first, releasing SDA for 1 bits. Increment `ptr` after bit 0 → RDATA_MACK.
- RDATA_MACK: sample SDA on SCL rise.
  - 0 (ACK) → RDATA with `mem[ptr]`.
  - 1 (NACK) → IGNORE.
- `ptr` wraps modulo 2^ADDR_W on both reads and writes. It persists across transactions, which gives current-address reads.
- Random read = write CTRL + AH + AL, repeated START, read CTRL. The data write in that sequence is never started, so nothing is committed.
- Simultaneous START/STOP with an SCL edge cannot occur (SCL is high). The START/STOP event takes priority over any bit-counter action in that clk.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `wr_pulse`=0, state=IDLE, `ptr`=0, bit counter=0, synchronizers=1 (idle bus). Memory contents are not reset.
- Pin-to-event latency: 3 clk (2 sync + edge detect).
- `sda_oe` update: 1 clk after a detected SCL fall, i.e. 4 clk after the pin edge. This gives hold time after SCL fall and ≥4 clk setup before the next rise at the minimum clk ratio.
- Memory read data is registered. It is fetched on entering RDATA/RDATA_MACK→RDATA, ≥1 clk before bit 7 is driven.
- `wr_pulse`: asserted the clk after the SCL rise that samples data bit 0.
- `busy`: rises the clk the CTRL match is decided. Falls the clk STOP/START is detected, or on entry to IGNORE.
- Asynchronous reset mid-transaction releases SDA immediately, combinationally through the register reset.

## Test plan
- Write 0xA0, 0x00, 0x10, 0x11, 0x22, 0x33, STOP with `chip_sel`=0 → every byte ACKed; `wr_pulse` ×3; mem[0x10..0x12] = 11/22/33; `ptr`=0x13.
- Random read: 0xA0, 0x00, 0x10, Sr, 0xA1, read 3 bytes with ACK, ACK, NACK, STOP → 0x11, 0x22, 0x33; `sda_oe` released after the NACK.
- Current-address read after a write to 0xFF with ADDR_W=8 → a write at 0xFF then a read of 2 bytes returns mem[0xFF] then mem[0x00] (wrap).
- Control byte 0xA2 with `chip_sel`=0 → no ACK (SDA high in the 9th clock), `busy` stays 0, no writes until the next START.
- `wp`=1: 0xA0, 0x00, 0x05, 0x5A → control and address bytes ACKed, data NACKed; mem[0x05] unchanged; `wr_pulse` never asserted.
- Reset or STOP mid-byte: `rst_n` low during read bit 3 while `sda_oe`=1 → `sda_oe`=0 at once; the next transaction (write 0xA0, 0x00, 0x00, 0x77) is ACKed normally.

Source files
------------

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24xx serial EEPROM: two-byte word address, sequential
// read/write, persistent wrapping pointer. The bus is oversampled by clk.
module i2c_eeprom_target #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [3:0]  DEV_ID = 4'b1010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [2:0] chip_sel,
    input  logic       wp,
    output logic       busy,
    output logic       wr_pulse
);
    typedef enum logic [3:0] {
        IDLE, CTRL, CTRL_ACK, AH, AH_ACK, AL, AL_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q, ah_q, rd_sh;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        mem [0:(2**ADDR_W)-1];

    logic [7:0] byte_in;
    logic last_bit, ctrl_match;
    logic sda_oe_d, busy_d, mem_we, ptr_inc, ptr_load, ah_load;
    logic rd_load, rd_shift, shift_en, cnt_inc, cnt_clr;

    // Synchronizers reset to 1 so an idle bus is seen as idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign last_bit   = scl_rise && (bit_cnt == 3'd7);
    assign ctrl_match = (byte_in[7:4] == DEV_ID) && (byte_in[3:1] == chip_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Byte states advance on the 8th rise; ACK states advance on the 9th rise.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = CTRL;
        end else if (stop_det) begin
            state_d = IDLE;
        end else if (scl_rise) begin
            case (state_q)
                CTRL:       if (last_bit) state_d = ctrl_match ? CTRL_ACK : IGNORE;
                CTRL_ACK:   state_d = shift_q[0] ? RDATA : AH;
                AH:         if (last_bit) state_d = AH_ACK;
                AH_ACK:     state_d = AL;
                AL:         if (last_bit) state_d = AL_ACK;
                AL_ACK:     state_d = WDATA;
                WDATA:      if (last_bit) state_d = wp ? IGNORE : WDATA_ACK;
                WDATA_ACK:  state_d = WDATA;
                RDATA:      if (last_bit) state_d = RDATA_MACK;
                RDATA_MACK: state_d = sda_s ? IGNORE : RDATA;
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sda_oe_d = sda_oe;
        busy_d   = busy;
        mem_we   = 1'b0;
        ptr_inc  = 1'b0;
        ptr_load = 1'b0;
        ah_load  = 1'b0;
        rd_load  = 1'b0;
        rd_shift = 1'b0;
        shift_en = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        if (start_det || stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_clr  = 1'b1;
        end else begin
            if (scl_fall) begin
                case (state_q)
                    CTRL_ACK, AH_ACK, AL_ACK, WDATA_ACK: sda_oe_d = 1'b1;
                    RDATA: begin
                        sda_oe_d = ~rd_sh[7];
                        rd_shift = 1'b1;
                    end
                    default: sda_oe_d = 1'b0;
                endcase
            end
            if (scl_rise) begin
                case (state_q)
                    CTRL, AH, AL, WDATA: begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                    RDATA:   cnt_inc = 1'b1;
                    default: cnt_clr = 1'b1;
                endcase
            end
            if (last_bit && state_q == CTRL)
                busy_d = ctrl_match;
            else if (state_d == IGNORE && state_q != IGNORE)
                busy_d = 1'b0;
            mem_we   = last_bit && (state_q == WDATA) && !wp;
            ptr_inc  = mem_we || (last_bit && state_q == RDATA);
            ah_load  = scl_rise && (state_q == AH_ACK);
            ptr_load = scl_rise && (state_q == AL_ACK);
            rd_load  = scl_rise && (state_d == RDATA) && (state_q != RDATA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            ah_q     <= '0;
            rd_sh    <= '0;
            ptr_q    <= '0;
        end else begin
            sda_oe   <= sda_oe_d;
            busy     <= busy_d;
            wr_pulse <= mem_we;
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift_q <= byte_in;
            if (ah_load)  ah_q    <= shift_q;
            // Upper received address bits beyond ADDR_W are dropped here.
            if (ptr_load)     ptr_q <= ADDR_W'({ah_q, shift_q});
            else if (ptr_inc) ptr_q <= ptr_q + ADDR_W'(1);
            if (rd_load)       rd_sh <= mem[ptr_q];
            else if (rd_shift) rd_sh <= {rd_sh[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= byte_in;
    end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: a bit-banged I2C master drives the bus,
// and read data is checked against an expected-byte queue.
module tb_i2c_eeprom_target;
  localparam int Q = 80;  // quarter SCL period; SCL period is 32 clk

  logic       clk = 1'b0;
  logic       rst_n, scl, m_sda, wp;
  logic [2:0] chip_sel;
  logic       sda_oe, busy, wr_pulse, sda_line;

  int         total = 0;
  int         bad = 0;
  int         wr_count = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe;

  i2c_eeprom_target #(.ADDR_W(8), .DEV_ID(4'b1010)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .chip_sel (chip_sel),
    .wp       (wp),
    .busy     (busy),
    .wr_pulse (wr_pulse)
  );

  always @(negedge clk) begin
    if (wr_pulse) wr_count++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clk_bit(input logic b, output logic r);
    m_sda = b;
    #Q scl = 1'b1;
    #Q r = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic wbyte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic r, a;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    a = ~r;
    check(tag, a, exp_ack);
  endtask

  task automatic rbyte(input string tag, input logic nack);
    logic r;
    logic [7:0] d, e;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(nack, r);
    if (exp_q.size() == 0) e = 8'h00;
    else e = exp_q.pop_front();
    check(tag, d, e);
  endtask

  task automatic addr_phase(input string tag, input logic [7:0] ah, input logic [7:0] al);
    i2c_start;
    wbyte({tag, "_ctrl"}, 8'hA0, 1'b1);
    wbyte({tag, "_ah"}, ah, 1'b1);
    wbyte({tag, "_al"}, al, 1'b1);
  endtask

  // random read of n bytes from word address {0x00, al}; expectations pre-queued
  task automatic rand_read(input string tag, input logic [7:0] al, input int n);
    addr_phase(tag, 8'h00, al);
    i2c_start;
    wbyte({tag, "_rctrl"}, 8'hA1, 1'b1);
    for (int i = 0; i < n; i++) rbyte($sformatf("%s_d%0d", tag, i), i == n - 1);
    check({tag, "_released"}, sda_oe, 1'b0);
    i2c_stop;
  endtask

  initial begin
    logic r;
    rst_n = 1'b1;
    scl = 1'b1;
    m_sda = 1'b1;
    wp = 1'b0;
    chip_sel = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    #(3 * Q - 1) rst_n = 1'b1;
    #Q;

    // seed 0x13 so the pointer after the main write can be read back
    addr_phase("seed", 8'h00, 8'h13);
    wbyte("seed_d", 8'h44, 1'b1);
    i2c_stop;

    busy_seen = 1'b0;
    addr_phase("wr", 8'h00, 8'h10);
    wbyte("wr_d0", 8'h11, 1'b1);
    wbyte("wr_d1", 8'h22, 1'b1);
    wbyte("wr_d2", 8'h33, 1'b1);
    check("wr_busy_seen", busy_seen, 1'b1);
    i2c_stop;
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_pulse_count", wr_count, 4);

    // current-address read: pointer must sit at 0x13
    exp_q.push_back(8'h44);
    i2c_start;
    wbyte("cur_ctrl", 8'hA1, 1'b1);
    rbyte("cur_d0", 1'b1);
    i2c_stop;

    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    rand_read("rr", 8'h10, 3);
    check("rr_no_write", wr_count, 4);

    // write across 0xFF, then re-address 0xFF with nonzero high byte and read across the wrap
    addr_phase("wrap_w", 8'h00, 8'hFF);
    wbyte("wrap_w_d0", 8'hC3, 1'b1);
    wbyte("wrap_w_d1", 8'h3C, 1'b1);
    i2c_stop;
    check("wrap_wr_count", wr_count, 6);
    addr_phase("wrap_a", 8'h12, 8'hFF);
    i2c_stop;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h3C);
    i2c_start;
    wbyte("wrap_rctrl", 8'hA1, 1'b1);
    rbyte("wrap_d0", 1'b0);
    rbyte("wrap_d1", 1'b1);
    i2c_stop;

    // wrong chip select: no ACK, no busy, no writes
    busy_seen = 1'b0;
    i2c_start;
    wbyte("cs_a2_nack", 8'hA2, 1'b0);
    wbyte("cs_a2_data", 8'h55, 1'b0);
    i2c_stop;
    check("cs_a2_busy", busy_seen, 1'b0);
    check("cs_a2_wr_count", wr_count, 6);
    chip_sel = 3'd2;
    i2c_start;
    wbyte("cs2_a4_ack", 8'hA4, 1'b1);
    i2c_stop;
    i2c_start;
    wbyte("cs2_a0_nack", 8'hA0, 1'b0);
    i2c_stop;
    chip_sel = 3'd0;

    // write protect
    addr_phase("wp_seed", 8'h00, 8'h05);
    wbyte("wp_seed_d", 8'h99, 1'b1);
    i2c_stop;
    check("wp_seed_count", wr_count, 7);
    wp = 1'b1;
    addr_phase("wp", 8'h00, 8'h05);
    wbyte("wp_data_nack", 8'h5A, 1'b0);
    i2c_stop;
    check("wp_no_pulse", wr_count, 7);
    wp = 1'b0;
    exp_q.push_back(8'h99);
    rand_read("wp_rd", 8'h05, 1);

    // reset while the target drives read bit 3 (0x11 -> bit 3 is 0)
    addr_phase("rst", 8'h00, 8'h10);
    i2c_start;
    wbyte("rst_rctrl", 8'hA1, 1'b1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, r);
    check("rst_bit3_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_release", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    scl = 1'b1;
    m_sda = 1'b1;
    #(Q - 1) rst_n = 1'b1;
    #Q;
    addr_phase("post", 8'h00, 8'h00);
    wbyte("post_d", 8'h77, 1'b1);
    i2c_stop;
    check("post_wr_count", wr_count, 8);
    exp_q.push_back(8'h77);
    rand_read("post_rd", 8'h00, 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
